sprite_memory_reader: RTL and testbench
=======================================

// Module: sprite_memory_reader
// PURPOSE
//  Read side of the sprite path. Sprite printers issue enable/address/element; this block
//  turns them into pixel colour: registered fetch from QTD_MEMORY_ELEMENT sprite RAM banks,
//  transparency/background resolution, blanking. Also loads the banks from a host write
//  port; writes happen only during blanking. Sits between the movement/print logic and the VGA output.
// PARAMETERS
//  QTD_MEMORY_ELEMENT  4       number of sprite banks; width of the one-hot element select
//  ADDRESS_MEMORY      10      bank address width; each bank holds 2**ADDRESS_MEMORY words
//  COLOR_WIDTH         9       pixel word width (RGB 3:3:3)
//  TRANSPARENT         9'h1FF  stored value meaning "no sprite pixel"
//  BG_COLOR            9'h000  colour when no sprite hit in the active area
// PORTS
//  clk          in   1                    system clock; all logic on posedge
//  reset        in   1                    synchronous, active-low; reset==0 clears all state
//  videoEnable  in   1                    active-video flag, pixel-aligned with enable/address/element
//  enable       in   1                    sprite printer hit for the current pixel
//  address      in   ADDRESS_MEMORY       word address inside the selected bank
//  element      in   QTD_MEMORY_ELEMENT   one-hot bank select
//  wr_req       in   1                    host write request (4-phase handshake)
//  wr_bank      in   8                    bank index for the write
//  wr_addr      in   ADDRESS_MEMORY       write word address
//  wr_data      in   COLOR_WIDTH          write data
//  wr_ack       out  1                    write-complete handshake acknowledge
//  wr_err       out  1                    1-cycle pulse: wr_bank >= QTD_MEMORY_ELEMENT, write dropped
//  rgb          out  COLOR_WIDTH          resolved pixel colour
//  video_en_out out  1                    videoEnable delayed to align with rgb
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - rgb, video_en_out, wr_ack, wr_err and all pipeline valid bits go to 0; write FSM goes to IDLE.
//  - RAM contents are NOT cleared.
//  Read pipeline, fixed latency 2 clk:
//  - S0 (cycle N): register videoEnable, enable&videoEnable as hit, address, element.
//  - Bank pick: lowest-index set bit of element wins. element==0 forces hit=0.
//  - S1 (N+1): synchronous RAM read of the picked bank at the registered address.
//  - S2 (N+2): rgb = 0 if the delayed videoEnable==0.
//    Else rgb = data if hit && data!=TRANSPARENT; else rgb = BG_COLOR.
//  - video_en_out = videoEnable delayed by 2. Pipeline runs every cycle with no stall.
//  Write FSM (IDLE, WAIT_BLANK, WRITE, ACK):
//  - IDLE: on wr_req==1, capture wr_bank/addr/data -> WAIT_BLANK.
//  - WAIT_BLANK: stay while videoEnable==1 at the S0 input; when it is 0 -> WRITE.
//  - WRITE: one cycle; write the captured word if bank is in range, else pulse wr_err -> ACK.
//  - ACK: wr_ack=1; hold until wr_req==0, then wr_ack=0 -> IDLE.
//  - Host must hold wr_* stable from wr_req rise until wr_ack rise.
//  - A write never coincides with a read whose hit is 1, because writes occur only while videoEnable==0.
//  - Read-during-write of the same word: the S1 read returns the old data.
//  - wr_req dropped before ACK: not allowed. The captured write still completes and ACK waits for wr_req==0, which holds immediately.
//  - Reset mid-operation: FSM -> IDLE and a pending (unwritten) write is lost. A write already done stays done.
// TESTING
//  - Reset: hold reset=0 3 clk with wr_req=1 -> rgb=0, wr_ack=0, video_en_out=0, no RAM write.
//  - Load/read: write bank1 addr 5 = 9'h0A3 during blanking, wait for wr_ack, release wr_req.
//    Then videoEnable=1, enable=1, element=4'b0010, address=5 at cycle N -> rgb=9'h0A3 at N+2.
//  - Transparency and background: the word holds 9'h1FF, enable=1, videoEnable=1 -> rgb=BG_COLOR.
//    Also enable=0, videoEnable=1 -> rgb=BG_COLOR; videoEnable=0 -> rgb=0.
//  - Deferred write: wr_req raised while videoEnable=1 for 20 clk -> no ack during those 20 clk.
//    Ack follows the WRITE cycle after videoEnable falls; readback matches the data.
//  - Bad bank and priority: wr_bank=4 -> wr_err pulses 1 cycle, wr_ack still completes, RAM unchanged.
//    element=4'b0110 reads bank1, not bank2.
//  - Reset mid-write: assert reset while in WAIT_BLANK -> after release, FSM is IDLE and the target word is unchanged.

Source files
------------

// File: rtl/sprite_memory_reader.sv
// ============================================================================
// Module  : sprite_memory_reader
// Brief   : Sprite bank fetch with transparency/background/blanking resolution,
//           plus a host write port that only commits during blanking.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sprite_memory_reader #(
  parameter int                     QTD_MEMORY_ELEMENT = 4,
  parameter int                     ADDRESS_MEMORY     = 10,
  parameter int                     COLOR_WIDTH        = 9,
  parameter logic [COLOR_WIDTH-1:0] TRANSPARENT        = 9'h1FF,
  parameter logic [COLOR_WIDTH-1:0] BG_COLOR           = 9'h000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          videoEnable,
  input  logic                          enable,
  input  logic [ADDRESS_MEMORY-1:0]     address,
  input  logic [QTD_MEMORY_ELEMENT-1:0] element,
  input  logic                          wr_req,
  input  logic [7:0]                    wr_bank,
  input  logic [ADDRESS_MEMORY-1:0]     wr_addr,
  input  logic [COLOR_WIDTH-1:0]        wr_data,
  output logic                          wr_ack,
  output logic                          wr_err,
  output logic [COLOR_WIDTH-1:0]        rgb,
  output logic                          video_en_out
);

  localparam int c_BW    = (QTD_MEMORY_ELEMENT > 1) ? $clog2(QTD_MEMORY_ELEMENT) : 1;
  localparam int c_DEPTH = 2 ** (c_BW + ADDRESS_MEMORY);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_WRITE      = 2'd2,
    ST_ACK        = 2'd3
  } state_t;

  // All banks share one array; the bank index forms the upper address bits.
  logic [COLOR_WIDTH-1:0]           r_mem [0:c_DEPTH-1];

  logic [c_BW-1:0]                  w_pick_bank;
  logic                             w_pick_any;
  logic                             r_ve0, r_hit0, r_ve1, r_hit1;
  logic [ADDRESS_MEMORY-1:0]        r_addr0;
  logic [c_BW-1:0]                  r_bank0;
  logic [COLOR_WIDTH-1:0]           r_rdata;

  state_t                           r_state, w_next;
  logic [7:0]                       r_wbank;
  logic [ADDRESS_MEMORY-1:0]        r_waddr;
  logic [COLOR_WIDTH-1:0]           r_wdata;
  logic                             w_bank_ok;
  logic                             w_we;
  logic [c_BW+ADDRESS_MEMORY-1:0]   w_wr_index;

  // Descending scan so the lowest set bit is the last assignment and wins.
  always_comb begin
    w_pick_bank = '0;
    w_pick_any  = 1'b0;
    for (int i = QTD_MEMORY_ELEMENT - 1; i >= 0; i--) begin
      if (element[i]) begin
        w_pick_bank = c_BW'(i);
        w_pick_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ve0        <= 1'b0;
      r_hit0       <= 1'b0;
      r_ve1        <= 1'b0;
      r_hit1       <= 1'b0;
      rgb          <= '0;
      video_en_out <= 1'b0;
    end else begin
      r_ve0        <= videoEnable;
      r_hit0       <= enable & videoEnable & w_pick_any;
      r_ve1        <= r_ve0;
      r_hit1       <= r_hit0;
      video_en_out <= r_ve1;
      if (!r_ve1)
        rgb <= '0;
      else if (r_hit1 && (r_rdata != TRANSPARENT))
        rgb <= r_rdata;
      else
        rgb <= BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    r_addr0 <= address;
    r_bank0 <= w_pick_bank;
  end

  // Read uses the pre-write contents when the same word is written this cycle.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_wr_index] <= r_wdata;
    r_rdata <= r_mem[{r_bank0, r_addr0}];
  end

  assign w_bank_ok  = (r_wbank < 8'(QTD_MEMORY_ELEMENT));
  assign w_wr_index = {r_wbank[c_BW-1:0], r_waddr};

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && wr_req) begin
      r_wbank <= wr_bank;
      r_waddr <= wr_addr;
      r_wdata <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    wr_ack = 1'b0;
    wr_err = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      ST_IDLE:       if (wr_req) w_next = ST_WAIT_BLANK;
      ST_WAIT_BLANK: if (!videoEnable) w_next = ST_WRITE;
      ST_WRITE: begin
        w_we   = w_bank_ok & reset;
        wr_err = ~w_bank_ok;
        w_next = ST_ACK;
      end
      ST_ACK: begin
        wr_ack = 1'b1;
        if (!wr_req) w_next = ST_IDLE;
      end
      default:       w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_memory_reader.sv
// Directed + randomized checks of sprite_memory_reader against a bank-array model.
`default_nettype none

module tb_sprite_memory_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       videoEnable, enable, wr_req;
  logic [9:0] address, wr_addr;
  logic [3:0] element;
  logic [7:0] wr_bank;
  logic [8:0] wr_data, rgb;
  logic       wr_ack, wr_err, video_en_out;

  int total = 0;
  int bad   = 0;

  logic [8:0] ref_mem [4][1024];
  int         wlist[$];

  typedef struct { logic [8:0] rgb; logic ve; } exp_t;
  exp_t       expq[$];

  sprite_memory_reader dut (
    .clk(clk), .reset(reset), .videoEnable(videoEnable), .enable(enable),
    .address(address), .element(element), .wr_req(wr_req), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .rgb(rgb), .video_en_out(video_en_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int low_bit(input logic [3:0] e);
    for (int i = 0; i < 4; i++) if (e[i]) return i;
    return -1;
  endfunction

  // Full 4-phase write during blanking; returns number of wr_err cycles seen.
  task automatic host_write(input logic [7:0] b, input logic [9:0] a, input logic [8:0] d,
                            output int errs);
    int n;
    videoEnable = 1'b0;
    wr_bank = b; wr_addr = a; wr_data = d; wr_req = 1'b1;
    errs = 0; n = 0;
    do begin
      tick();
      if (wr_err === 1'b1) errs++;
      n++;
    end while (wr_ack !== 1'b1 && n < 200);
    chk("ack_arrives", {15'd0, wr_ack}, 16'd1);
    wr_req = 1'b0;
    tick();
    chk("ack_release", {15'd0, wr_ack}, 16'd0);
    if (b < 8'd4) begin
      ref_mem[b[1:0]][a] = d;
      wlist.push_back(int'(b) * 1024 + int'(a));
    end
  endtask

  task automatic do_read(input logic [3:0] elem, input logic [9:0] a, input logic en,
                         input logic ve, input logic [8:0] exp_rgb, input string tag);
    videoEnable = ve; enable = en; element = elem; address = a;
    tick();
    videoEnable = 1'b0; enable = 1'b0; element = 4'd0;
    tick();
    tick();
    chk(tag, {7'd0, rgb}, {7'd0, exp_rgb});
    chk({tag, "_ve"}, {15'd0, video_en_out}, {15'd0, ve});
  endtask

  initial begin
    int         errs;
    int         pick, b, lb;
    logic [3:0] m, elem;
    logic [9:0] a;
    logic [8:0] d;
    exp_t       e, got;

    reset = 1'b0; videoEnable = 1'b0; enable = 1'b0; address = '0; element = '0;
    wr_req = 1'b1; wr_bank = 8'd0; wr_addr = 10'd7; wr_data = 9'h111;
    repeat (3) tick();
    chk("reset_rgb", {7'd0, rgb}, 16'd0);
    chk("reset_ack", {15'd0, wr_ack}, 16'd0);
    chk("reset_ven", {15'd0, video_en_out}, 16'd0);
    wr_req = 1'b0; reset = 1'b1;
    tick();

    host_write(8'd1, 10'd5, 9'h0A3, errs);
    chk("load_err", 16'(errs), 16'd0);
    do_read(4'b0010, 10'd5, 1'b1, 1'b1, 9'h0A3, "load_read");

    host_write(8'd3, 10'd20, 9'h1FF, errs);
    do_read(4'b1000, 10'd20, 1'b1, 1'b1, 9'h000, "transparent_bg");
    do_read(4'b0010, 10'd5, 1'b0, 1'b1, 9'h000, "noenable_bg");
    do_read(4'b0010, 10'd5, 1'b1, 1'b0, 9'h000, "blank_zero");
    do_read(4'b0000, 10'd5, 1'b1, 1'b1, 9'h000, "noelem_bg");

    // Deferred write: held off by active video, then commits two edges after blanking.
    videoEnable = 1'b1; enable = 1'b0;
    wr_bank = 8'd2; wr_addr = 10'd300; wr_data = 9'h15A; wr_req = 1'b1;
    errs = 0;
    repeat (20) begin
      tick();
      if (wr_ack !== 1'b0) errs++;
    end
    chk("deferred_no_ack", 16'(errs), 16'd0);
    videoEnable = 1'b0;
    tick();
    chk("deferred_write_cycle", {15'd0, wr_ack}, 16'd0);
    tick();
    chk("deferred_ack", {15'd0, wr_ack}, 16'd1);
    wr_req = 1'b0;
    tick();
    chk("deferred_release", {15'd0, wr_ack}, 16'd0);
    ref_mem[2][300] = 9'h15A; wlist.push_back(2 * 1024 + 300);
    do_read(4'b0100, 10'd300, 1'b1, 1'b1, 9'h15A, "deferred_read");

    host_write(8'd0, 10'd5, 9'h0C3, errs);
    host_write(8'd2, 10'd5, 9'h07E, errs);
    host_write(8'd4, 10'd5, 9'h1AA, errs);
    chk("badbank_err_pulses", 16'(errs), 16'd1);
    do_read(4'b0001, 10'd5, 1'b1, 1'b1, 9'h0C3, "badbank_unchanged");
    do_read(4'b0110, 10'd5, 1'b1, 1'b1, 9'h0A3, "priority_bank1");

    // Reset while a write waits for blanking drops the write.
    host_write(8'd2, 10'd9, 9'h0F0, errs);
    videoEnable = 1'b1;
    wr_bank = 8'd2; wr_addr = 10'd9; wr_data = 9'h123; wr_req = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; wr_req = 1'b0; videoEnable = 1'b0;
    errs = 0;
    repeat (5) begin
      tick();
      if (wr_ack !== 1'b0) errs++;
    end
    chk("midreset_idle", 16'(errs), 16'd0);
    do_read(4'b0100, 10'd9, 1'b1, 1'b1, 9'h0F0, "midreset_word");

    // Reset held during blanking with a request must not touch RAM.
    host_write(8'd0, 10'd7, 9'h055, errs);
    reset = 1'b0; wr_req = 1'b1;
    wr_bank = 8'd0; wr_addr = 10'd7; wr_data = 9'h111;
    repeat (3) tick();
    wr_req = 1'b0; reset = 1'b1;
    tick();
    do_read(4'b0001, 10'd7, 1'b1, 1'b1, 9'h055, "reset_no_write");

    for (int i = 0; i < 16; i++) begin
      b = $urandom_range(0, 3);
      a = 10'($urandom_range(0, 1023));
      d = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
      host_write(8'(b), a, d, errs);
      chk("rand_write_err", 16'(errs), 16'd0);
    end

    expq.delete();
    for (int k = 0; k < 302; k++) begin
      if (k < 300) begin
        pick = wlist[$urandom_range(0, wlist.size() - 1)];
        b = pick / 1024;
        a = 10'(pick % 1024);
        m = 4'hF << (b + 1);
        elem = ($urandom_range(0, 7) == 0) ? 4'd0 : ((4'($urandom) & m) | (4'd1 << b));
        videoEnable = ($urandom_range(0, 3) != 0);
        enable = $urandom_range(0, 1);
        element = elem; address = a;
      end else begin
        videoEnable = 1'b0; enable = 1'b0; element = 4'd0;
      end
      lb = low_bit(element);
      e.ve = videoEnable;
      if (!videoEnable)
        e.rgb = 9'h000;
      else if (enable && lb >= 0 && ref_mem[lb][address] != 9'h1FF)
        e.rgb = ref_mem[lb][address];
      else
        e.rgb = 9'h000;
      expq.push_back(e);
      tick();
      if (expq.size() == 3) begin
        got = expq.pop_front();
        chk("rand_rgb", {7'd0, rgb}, {7'd0, got.rgb});
        chk("rand_ven", {15'd0, video_en_out}, {15'd0, got.ve});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
